exe_stage: RTL and testbench

Execute stage of the 5-stage ARM pipeline. It consumes the ID/EX pipeline register outputs and computes Val2 from the shifter operand, the ALU result with NZCV flags, and the branch target address. It also runs an iterative 32x32 multiplier that stalls the front of the pipeline while a MUL is in flight. Every result except the multiplier product is combinational and is captured by the EX/MEM pipeline register.

---
 rtl/arm_exe_pkg.sv | 33 +++
 rtl/seq_multiplier.sv | 79 +++++++
 rtl/exe_stage.sv | 119 +++++++++++
 tb/tb_exe_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_exe_pkg.sv
// Shared constants, types and helpers for the ARM execute stage.
package arm_exe_pkg;

  localparam int unsigned AddrWidth  = 32;
  localparam int unsigned RegWidth   = 32;
  localparam int unsigned CmdWidth   = 4;
  localparam int unsigned SimmWidth  = 24;
  localparam int unsigned ShOpWidth  = 12;

  localparam logic [CmdWidth-1:0] ExeMov = 4'b0001;
  localparam logic [CmdWidth-1:0] ExeMvn = 4'b1001;
  localparam logic [CmdWidth-1:0] ExeAdd = 4'b0010;
  localparam logic [CmdWidth-1:0] ExeAdc = 4'b0011;
  localparam logic [CmdWidth-1:0] ExeSub = 4'b0100;
  localparam logic [CmdWidth-1:0] ExeSbc = 4'b0101;
  localparam logic [CmdWidth-1:0] ExeAnd = 4'b0110;
  localparam logic [CmdWidth-1:0] ExeOrr = 4'b0111;
  localparam logic [CmdWidth-1:0] ExeEor = 4'b1000;

  localparam logic [1:0] ShiftLsl = 2'b00;
  localparam logic [1:0] ShiftLsr = 2'b01;
  localparam logic [1:0] ShiftAsr = 2'b10;
  localparam logic [1:0] ShiftRor = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  // Rotate right; the doubled word makes a zero rotate amount fall out naturally.
  function automatic logic [RegWidth-1:0] ror32(input logic [RegWidth-1:0] v,
                                                input logic [4:0] amt);
    return RegWidth'({v, v} >> amt);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier returning the low word of a*b.
module seq_multiplier
  import arm_exe_pkg::*;
#(
  parameter int unsigned MUL_ITER = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [RegWidth-1:0] a,
  input  logic [RegWidth-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [RegWidth-1:0] product
);

  localparam int unsigned CntW = $clog2(MUL_ITER + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MUL_ITER - 1);

  mul_state_t          state_q, state_d;
  logic [RegWidth-1:0] mcand_q, mcand_d;
  logic [RegWidth-1:0] mplier_q, mplier_d;
  logic [RegWidth-1:0] acc_q, acc_d;
  logic [CntW-1:0]     count_q, count_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // A dropped start means the instruction was flushed.
        if (!start) begin
          state_d = IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CntW'(1);
          if (count_q == LastCnt) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == BUSY);
  assign done    = (state_q == DONE);
  assign product = acc_q;

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: Val2 shifter, ALU with NZCV, branch adder and the MUL stall control.
module exe_stage
  import arm_exe_pkg::*;
#(
  parameter int unsigned MUL_ITER = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read_en_in,
  input  logic                 mem_write_en_in,
  input  logic                 immediate_in,
  input  logic                 is_mul_in,
  input  logic [CmdWidth-1:0]  execute_command_in,
  input  logic [AddrWidth-1:0] PC_in,
  input  logic [RegWidth-1:0]  reg_file_in1,
  input  logic [RegWidth-1:0]  reg_file_in2,
  input  logic [SimmWidth-1:0] signed_immediate_in,
  input  logic [ShOpWidth-1:0] shift_operand_in,
  input  logic [3:0]           status_reg_in,
  output logic [RegWidth-1:0]  alu_result,
  output logic [3:0]           status_out,
  output logic [AddrWidth-1:0] branch_address,
  output logic                 stall
);

  logic [RegWidth-1:0] val2;
  logic [4:0]          sh_amt;
  logic [RegWidth-1:0] alu_out;
  logic [RegWidth-1:0] addend;
  logic                carry0;
  logic                arith;
  logic [RegWidth:0]   sum;
  logic                c_out, v_out;
  logic                c_in, v_in;
  logic                mul_busy, mul_done;
  logic [RegWidth-1:0] mul_product;
  logic                unused_sigs;

  assign c_in   = status_reg_in[1];
  assign v_in   = status_reg_in[0];
  assign sh_amt = shift_operand_in[11:7];

  always_comb begin
    val2 = '0;
    if (mem_read_en_in || mem_write_en_in) begin
      val2 = {{(RegWidth - ShOpWidth){1'b0}}, shift_operand_in};
    end else if (immediate_in) begin
      val2 = ror32({24'b0, shift_operand_in[7:0]}, {shift_operand_in[11:8], 1'b0});
    end else begin
      unique case (shift_operand_in[6:5])
        ShiftLsl: val2 = reg_file_in2 << sh_amt;
        ShiftLsr: val2 = reg_file_in2 >> sh_amt;
        ShiftAsr: val2 = $unsigned($signed(reg_file_in2) >>> sh_amt);
        ShiftRor: val2 = ror32(reg_file_in2, sh_amt);
        default:  val2 = reg_file_in2;
      endcase
    end
  end

  // Subtraction is Rn + ~Val2 + carry, so C comes out as NOT borrow directly.
  always_comb begin
    alu_out = '0;
    addend  = '0;
    carry0  = 1'b0;
    arith   = 1'b0;
    c_out   = c_in;
    v_out   = v_in;
    case (execute_command_in)
      ExeMov: alu_out = val2;
      ExeMvn: alu_out = ~val2;
      ExeAdd: begin addend = val2;  carry0 = 1'b0; arith = 1'b1; end
      ExeAdc: begin addend = val2;  carry0 = c_in; arith = 1'b1; end
      ExeSub: begin addend = ~val2; carry0 = 1'b1; arith = 1'b1; end
      ExeSbc: begin addend = ~val2; carry0 = c_in; arith = 1'b1; end
      ExeAnd: alu_out = reg_file_in1 & val2;
      ExeOrr: alu_out = reg_file_in1 | val2;
      ExeEor: alu_out = reg_file_in1 ^ val2;
      default: alu_out = '0;
    endcase
    sum = {1'b0, reg_file_in1} + {1'b0, addend} + {{RegWidth{1'b0}}, carry0};
    if (arith) begin
      alu_out = sum[RegWidth-1:0];
      c_out   = sum[RegWidth];
      v_out   = (reg_file_in1[RegWidth-1] == addend[RegWidth-1]) &&
                (sum[RegWidth-1] != reg_file_in1[RegWidth-1]);
    end
  end

  seq_multiplier #(
    .MUL_ITER(MUL_ITER)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (is_mul_in),
    .a      (reg_file_in1),
    .b      (reg_file_in2),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  always_comb begin
    if (is_mul_in) begin
      alu_result = mul_product;
      status_out = {mul_product[RegWidth-1], mul_product == '0, c_in, v_in};
    end else begin
      alu_result = alu_out;
      status_out = {alu_out[RegWidth-1], alu_out == '0, c_out, v_out};
    end
  end

  assign stall          = is_mul_in && !mul_done;
  assign branch_address = PC_in + {{6{signed_immediate_in[SimmWidth-1]}}, signed_immediate_in,
                                   2'b00};

  // Incoming N/Z are never consumed; busy is implied by "not done" for the stall.
  assign unused_sigs = ^{status_reg_in[3:2], mul_busy};

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: ALU/shifter/branch vectors and iterative MUL timing.
module tb_exe_stage;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [3:0]  st;
    logic [31:0] br;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_en_in, mem_write_en_in, immediate_in, is_mul_in;
  logic [3:0]  execute_command_in;
  logic [31:0] PC_in, reg_file_in1, reg_file_in2;
  logic [23:0] signed_immediate_in;
  logic [11:0] shift_operand_in;
  logic [3:0]  status_reg_in;
  logic [31:0] alu_result;
  logic [3:0]  status_out;
  logic [31:0] branch_address;
  logic        stall;

  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  always #5 clk = ~clk;

  exe_stage #(.MUL_ITER(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_read_en_in     (mem_read_en_in),
    .mem_write_en_in    (mem_write_en_in),
    .immediate_in       (immediate_in),
    .is_mul_in          (is_mul_in),
    .execute_command_in (execute_command_in),
    .PC_in              (PC_in),
    .reg_file_in1       (reg_file_in1),
    .reg_file_in2       (reg_file_in2),
    .signed_immediate_in(signed_immediate_in),
    .shift_operand_in   (shift_operand_in),
    .status_reg_in      (status_reg_in),
    .alu_result         (alu_result),
    .status_out         (status_out),
    .branch_address     (branch_address),
    .stall              (stall)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [31:0] res, input logic [3:0] st,
                              input logic [31:0] br);
    exp_t e;
    e.tag = tag;
    e.res = res;
    e.st  = st;
    e.br  = br;
    return e;
  endfunction

  task automatic set_ops(input logic [3:0] op, input logic mr, input logic mw, input logic im,
                         input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] so,
                         input logic [3:0] st, input logic [31:0] pc, input logic [23:0] si);
    execute_command_in  = op;
    mem_read_en_in      = mr;
    mem_write_en_in     = mw;
    immediate_in        = im;
    reg_file_in1        = rn;
    reg_file_in2        = rm;
    shift_operand_in    = so;
    status_reg_in       = st;
    PC_in               = pc;
    signed_immediate_in = si;
  endtask

  function automatic logic [31:0] ref_branch();
    return PC_in + 32'(longint'($signed(signed_immediate_in)) * 4);
  endfunction

  // Reference model built from the stimulus variables only.
  function automatic exp_t model_exe(input string tag);
    logic [31:0] v, r;
    logic [63:0] u;
    longint      s;
    int          amt;
    bit          c, vf;
    c  = status_reg_in[1];
    vf = status_reg_in[0];
    if (mem_read_en_in || mem_write_en_in) begin
      v = {20'b0, shift_operand_in};
    end else if (immediate_in) begin
      v = {24'b0, shift_operand_in[7:0]};
      for (int k = 0; k < 2 * int'(shift_operand_in[11:8]); k++) v = {v[0], v[31:1]};
    end else begin
      amt = int'(shift_operand_in[11:7]);
      v = reg_file_in2;
      case (shift_operand_in[6:5])
        2'b00: v = v << amt;
        2'b01: v = v >> amt;
        2'b10: for (int k = 0; k < amt; k++) v = {v[31], v[31:1]};
        default: for (int k = 0; k < amt; k++) v = {v[0], v[31:1]};
      endcase
    end
    r = 32'h0;
    case (execute_command_in)
      4'b0001: r = v;
      4'b1001: r = ~v;
      4'b0110: r = reg_file_in1 & v;
      4'b0111: r = reg_file_in1 | v;
      4'b1000: r = reg_file_in1 ^ v;
      4'b0010, 4'b0011: begin
        u  = 64'(reg_file_in1) + 64'(v) + ((execute_command_in[0] && c) ? 64'd1 : 64'd0);
        s  = longint'($signed(reg_file_in1)) + longint'($signed(v)) +
             ((execute_command_in[0] && c) ? 1 : 0);
        r  = u[31:0];
        c  = (u > 64'hFFFF_FFFF);
        vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0100, 4'b0101: begin
        u  = 64'(v) + ((execute_command_in[0] && !c) ? 64'd1 : 64'd0);
        s  = longint'($signed(reg_file_in1)) - longint'($signed(v)) -
             ((execute_command_in[0] && !c) ? 1 : 0);
        r  = s[31:0];
        c  = (64'(reg_file_in1) >= u);
        vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      default: r = 32'h0;
    endcase
    return mk(tag, r, {r[31], r == 32'h0, c, vf}, ref_branch());
  endfunction

  function automatic exp_t model_mul(input string tag);
    logic [31:0] p;
    p = 32'(64'(reg_file_in1) * 64'(reg_file_in2));
    return mk(tag, p, {p[31], p == 32'h0, status_reg_in[1:0]}, ref_branch());
  endfunction

  task automatic pop_check();
    exp_t e;
    check_val("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val({e.tag, "_stall"}, 32'(stall), 32'd0);
      check_val({e.tag, "_res"}, alu_result, e.res);
      check_val({e.tag, "_nzcv"}, 32'(status_out), 32'(e.st));
      check_val({e.tag, "_br"}, branch_address, e.br);
    end
  endtask

  task automatic run_comb(input exp_t e);
    sb.push_back(e);
    @(negedge clk);
    pop_check();
  endtask

  // Counts stalled cycles from the cycle in which the MUL is first presented.
  task automatic wait_mul(input string tag);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (stall === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check_val({tag, "_stalls"}, 32'(cnt), 32'd33);
    pop_check();
  endtask

  initial begin
    logic [3:0] ops [11] = '{4'h1, 4'h9, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h0, 4'hF};
    int mode;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    is_mul_in = 1'b0;
    set_ops(4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 12'h0, 4'h0, 32'h0, 24'h0);

    #2;
    check_val("rst_stall_idle", 32'(stall), 32'd0);
    is_mul_in = 1'b1;
    #1 check_val("rst_stall_mul", 32'(stall), 32'd1);
    is_mul_in = 1'b0;
    set_ops(4'h2, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 12'h080, 4'h0, 32'h40, 24'h1);
    sb.push_back(model_exe("rst_add"));
    #1 pop_check();
    @(posedge clk) #1 rst = 1'b1;

    @(posedge clk) #1 set_ops(4'h2, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0, 12'h001, 4'h0,
                              32'h0, 24'h0);
    run_comb(mk("add_ovf", 32'h8000_0000, 4'b1001, 32'h0));
    @(posedge clk) #1 set_ops(4'h4, 1'b0, 1'b0, 1'b0, 32'd5, 32'd5, 12'h000, 4'h0,
                              32'h0, 24'h0);
    run_comb(mk("sub_zero", 32'h0, 4'b0110, 32'h0));
    @(posedge clk) #1 set_ops(4'h1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 12'h4FF, 4'h0,
                              32'h0, 24'h0);
    run_comb(mk("mov_rot", 32'hFF00_0000, 4'b1000, 32'h0));
    @(posedge clk) #1 set_ops(4'h2, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 12'hFFF, 4'h0,
                              32'h0, 24'h0);
    run_comb(mk("ldr_addr", 32'h0000_10FF, 4'b0000, 32'h0));
    @(posedge clk) #1 set_ops(4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 12'h000, 4'h0,
                              32'h100, 24'hFFFFFE);
    run_comb(mk("branch_back", 32'h0, 4'b0100, 32'h0000_00F8));

    for (int i = 0; i < 24; i++) begin
      mode = int'($urandom_range(0, 2));
      @(posedge clk) #1
      set_ops(ops[$urandom_range(0, 10)], mode == 0 && i[0], mode == 0 && !i[0], mode == 1,
              $urandom, $urandom, 12'($urandom), 4'($urandom), $urandom, 24'($urandom));
      run_comb(model_exe($sformatf("rnd%0d", i)));
    end

    @(posedge clk) #1 set_ops(4'h0, 1'b0, 1'b0, 1'b0, 32'd7, 32'd6, 12'h000, 4'h0,
                              32'h0, 24'h0);
    is_mul_in = 1'b1;
    sb.push_back(mk("mul_7x6", 32'd42, 4'b0000, 32'h0));
    wait_mul("mul_7x6");
    @(posedge clk) #1 set_ops(4'h0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 12'h000, 4'b0011,
                              32'h0, 24'h0);
    sb.push_back(mk("mul_neg", 32'hFFFF_FFFE, 4'b1011, 32'h0));
    wait_mul("mul_neg");
    @(posedge clk) #1 set_ops(4'h0, 1'b0, 1'b0, 1'b0, $urandom, $urandom, 12'h000,
                              4'($urandom), $urandom, 24'($urandom));
    sb.push_back(model_mul("mul_rnd"));
    wait_mul("mul_rnd");
    @(posedge clk) #1 is_mul_in = 1'b0;
    set_ops(4'h7, 1'b0, 1'b0, 1'b1, 32'h0F00, 32'h0, 12'h1AB, 4'h2, 32'h200, 24'h10);
    run_comb(model_exe("after_mul"));

    @(posedge clk) #1 set_ops(4'h0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 12'h000, 4'h0,
                              32'h0, 24'h0);
    is_mul_in = 1'b1;
    repeat (11) @(negedge clk);
    rst = 1'b0;
    #1 check_val("rst_mid_stall_hi", 32'(stall), 32'd1);
    is_mul_in = 1'b0;
    #1 check_val("rst_mid_stall_lo", 32'(stall), 32'd0);
    is_mul_in = 1'b1;
    #1 check_val("rst_mid_stall_rehi", 32'(stall), 32'd1);
    @(posedge clk) #1 rst = 1'b1;
    set_ops(4'h0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h10, 12'h000, 4'h0, 32'h0, 24'h0);
    sb.push_back(mk("mul_after_rst", 32'h0001_2340, 4'b0000, 32'h0));
    wait_mul("mul_after_rst");
    @(posedge clk) #1 is_mul_in = 1'b0;
    set_ops(4'h5, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h1, 12'h000, 4'h0, 32'h0, 24'h0);
    run_comb(model_exe("sbc_tail"));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
